// File: rtl/dmem_responder.sv
// Load/store responder for the multicycle core: a single outstanding word request, served from
// internal RAM or the toggle register after WAIT_STATES wait cycles, answered by a one-cycle pulse.
module dmem_responder #(
    parameter int          MEM_WORDS   = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] TOGGLE_ADDR = 32'd52
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] toggle_value
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Replace the strobed bytes of old_word with the matching bytes of new_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic [3:0]         cnt_r;
    logic [3:0]         cnt_next_s;
    logic               ready_r;
    logic               write_r;
    logic [31:0]        addr_r;
    logic [31:0]        wdata_r;
    logic [3:0]         wstrb_r;
    logic               rsp_valid_r;
    logic [31:0]        rsp_rdata_r;
    logic               rsp_err_r;
    logic [31:0]        toggle_r;
    logic [31:0]        mem_r [MEM_WORDS];

    logic               accept_s;
    logic               commit_s;
    logic               misaligned_s;
    logic               in_range_s;
    logic               hit_toggle_s;
    logic               hit_ram_s;
    logic               err_s;
    logic [IDX_W-1:0]   ram_idx_s;
    logic [31:0]        rd_word_s;

    assign accept_s  = (state_r == ST_IDLE) && req_valid;
    assign commit_s  = (state_r == ST_RESP);
    assign ram_idx_s = addr_r[IDX_W+1:2];

    // Next-state and wait-counter logic.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next_s = ST_WAIT;
                    cnt_next_s   = 4'(WAIT_STATES);
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = ST_RESP;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Address decode of the latched request; toggle register shadows its RAM word.
    always_comb begin
        misaligned_s = (addr_r[1:0] != 2'b00);
        in_range_s   = ({2'b00, addr_r[31:2]} < 32'(MEM_WORDS));
        hit_toggle_s = !misaligned_s && (addr_r == TOGGLE_ADDR);
        hit_ram_s    = !misaligned_s && !hit_toggle_s && in_range_s;
        err_s        = !hit_toggle_s && !hit_ram_s;
        rd_word_s    = 32'd0;
        if (write_r || err_s) begin
            rd_word_s = 32'd0;
        end else if (hit_toggle_s) begin
            rd_word_s = toggle_r;
        end else begin
            rd_word_s = mem_r[ram_idx_s];
        end
    end

    // FSM state, ready flag and request capture.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            ready_r <= 1'b1;
            write_r <= 1'b0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            wstrb_r <= 4'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            ready_r <= (state_next_s == ST_IDLE);
            if (accept_s) begin
                write_r <= req_write;
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
                wstrb_r <= req_wstrb;
            end else begin
                write_r <= write_r;
            end
        end
    end

    // Response registers and toggle register update at the commit edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
            toggle_r    <= 32'd0;
        end else begin
            rsp_valid_r <= commit_s;
            if (commit_s) begin
                rsp_rdata_r <= rd_word_s;
                rsp_err_r   <= err_s;
            end else begin
                rsp_err_r   <= rsp_err_r;
            end
            if (commit_s && write_r && hit_toggle_s) begin
                toggle_r <= merge_bytes(toggle_r, wdata_r, wstrb_r);
            end else begin
                toggle_r <= toggle_r;
            end
        end
    end

    // RAM store port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (commit_s && write_r && hit_ram_s) begin
            mem_r[ram_idx_s] <= merge_bytes(mem_r[ram_idx_s], wdata_r, wstrb_r);
        end
    end

    assign req_ready    = ready_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_rdata    = rsp_rdata_r;
    assign rsp_err      = rsp_err_r;
    assign toggle_value = toggle_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 (WAIT_STATES=1) carries the functional tests,
// instances 1 (WAIT_STATES=0) and 2 (WAIT_STATES=3) cover request spacing and reset abort.
module tb_dmem_responder;

    logic              clk = 1'b0;
    logic              resetn;
    logic [2:0]        req_valid;
    logic [2:0]        req_ready;
    logic              req_write;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic [2:0]        rsp_valid;
    logic [2:0][31:0]  rsp_rdata;
    logic [2:0]        rsp_err;
    logic [2:0][31:0]  toggle_value;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_mem [int];
    logic [31:0] model_tog = 32'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .MEM_WORDS   (1024),
            .WAIT_STATES (g == 0 ? 1 : (g == 1 ? 0 : 3)),
            .TOGGLE_ADDR (32'd52)
        ) u_dut (
            .clk          (clk),
            .resetn       (resetn),
            .req_valid    (req_valid[g]),
            .req_ready    (req_ready[g]),
            .req_write    (req_write),
            .req_addr     (req_addr),
            .req_wdata    (req_wdata),
            .req_wstrb    (req_wstrb),
            .rsp_valid    (rsp_valid[g]),
            .rsp_rdata    (rsp_rdata[g]),
            .rsp_err      (rsp_err[g]),
            .toggle_value (toggle_value[g])
        );
    end

    // Reference model for instance 0: pushes the expected response onto the scoreboard.
    task automatic model_push(input logic w, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] s);
        exp_t        e;
        logic [31:0] word;
        int          idx;
        e.rdata = 32'd0;
        e.err   = 1'b0;
        idx = int'(a[31:2]);
        if (a[1:0] != 2'b00) begin
            e.err = 1'b1;
        end else if (a == 32'd52) begin
            if (w) begin
                for (int i = 0; i < 4; i++) if (s[i]) model_tog[8*i +: 8] = wd[8*i +: 8];
            end else begin
                e.rdata = model_tog;
            end
        end else if (a[31:2] < 30'd1024) begin
            word = model_mem.exists(idx) ? model_mem[idx] : 32'hxxxxxxxx;
            if (w) begin
                for (int i = 0; i < 4; i++) if (s[i]) word[8*i +: 8] = wd[8*i +: 8];
                model_mem[idx] = word;
            end else begin
                e.rdata = word;
            end
        end else begin
            e.err = 1'b1;
        end
        sb_q.push_back(e);
    endtask

    // Drives one request into instance d and collects its response (no checking here).
    task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s, output logic [31:0] rd, output logic er,
                        output int lat, output logic one, output logic [31:0] tog,
                        output logic to);
        int acc;
        int t;
        to = 1'b0; rd = 32'd0; er = 1'b0; lat = -1; one = 1'b0; tog = 32'd0;
        @(negedge clk);
        req_write = w; req_addr = a; req_wdata = wd; req_wstrb = s;
        req_valid[d] = 1'b1;
        t = 0;
        while (req_ready[d] !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) to = 1'b1;
        acc = cyc + 1;
        @(negedge clk);
        req_valid[d] = 1'b0;
        t = 0;
        while (rsp_valid[d] !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) to = 1'b1;
        lat = cyc - acc;
        rd  = rsp_rdata[d];
        er  = rsp_err[d];
        tog = toggle_value[d];
        @(negedge clk);
        one = (rsp_valid[d] === 1'b0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b111 || rsp_valid !== 3'b000 || rsp_err !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b valid=%b err=%b want 111 000 000", req_ready, rsp_valid, rsp_err);
        end
        checks++;
        if (rsp_rdata[0] !== 32'd0 || toggle_value[0] !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h toggle=%h want 0 0", rsp_rdata[0], toggle_value[0]);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd, tog; logic er, one, to; int lat; exp_t ex;
        model_push(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
        xact(0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, rd, er, lat, one, tog, to);
        ex = sb_q.pop_front();
        checks++;
        if (to || rd !== ex.rdata || er !== ex.err) begin
            errors++;
            $display("FAIL store_rsp: rdata=%h err=%b to=%b want %h %b", rd, er, to, ex.rdata, ex.err);
        end
        checks++;
        if (lat != 3 || !one) begin
            errors++;
            $display("FAIL store_timing: latency=%0d single=%b want 3 1", lat, one);
        end
        model_push(1'b0, 32'h100, 32'h0, 4'h0);
        xact(0, 1'b0, 32'h100, 32'h0, 4'h0, rd, er, lat, one, tog, to);
        ex = sb_q.pop_front();
        checks++;
        if (to || rd !== ex.rdata || er !== ex.err) begin
            errors++;
            $display("FAIL load_rsp: rdata=%h err=%b to=%b want %h %b", rd, er, to, ex.rdata, ex.err);
        end
        checks++;
        if (lat != 3 || !one) begin
            errors++;
            $display("FAIL load_timing: latency=%0d single=%b want 3 1", lat, one);
        end
    endtask

    task automatic test_toggle();
        logic [31:0] rd, tog; logic er, one, to; int lat; exp_t ex;
        model_push(1'b1, 32'd52, 32'h00000001, 4'hF);
        xact(0, 1'b1, 32'd52, 32'h00000001, 4'hF, rd, er, lat, one, tog, to);
        ex = sb_q.pop_front();
        checks++;
        if (to || rd !== ex.rdata || er !== ex.err || tog !== model_tog) begin
            errors++;
            $display("FAIL toggle_store: rdata=%h err=%b toggle=%h want %h %b %h", rd, er, tog, ex.rdata, ex.err, model_tog);
        end
        model_push(1'b0, 32'd52, 32'h0, 4'h0);
        xact(0, 1'b0, 32'd52, 32'h0, 4'h0, rd, er, lat, one, tog, to);
        ex = sb_q.pop_front();
        checks++;
        if (to || rd !== ex.rdata || er !== ex.err) begin
            errors++;
            $display("FAIL toggle_load: rdata=%h err=%b want %h %b", rd, er, ex.rdata, ex.err);
        end
    endtask

    task automatic test_byte_strobe();
        logic [31:0] rd, tog; logic er, one, to; int lat; exp_t ex;
        logic [3:0]  strb_tab [4] = '{4'hF, 4'b0101, 4'b0000, 4'h0};
        logic [31:0] data_tab [4] = '{32'h11223344, 32'hAABBCCDD, 32'h99999999, 32'h0};
        for (int i = 0; i < 4; i++) begin
            model_push(i < 3, 32'h200, data_tab[i], strb_tab[i]);
            xact(0, i < 3, 32'h200, data_tab[i], strb_tab[i], rd, er, lat, one, tog, to);
            ex = sb_q.pop_front();
            checks++;
            if (to || rd !== ex.rdata || er !== ex.err) begin
                errors++;
                $display("FAIL strobe_%0d: rdata=%h err=%b want %h %b", i, rd, er, ex.rdata, ex.err);
            end
        end
        checks++;
        if (rd !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL strobe_merge: rdata=%h want 11bb33dd", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, tog; logic er, one, to; int lat; exp_t ex;
        logic        w_tab [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] a_tab [5] = '{32'h102, 32'h1000, 32'hFFC, 32'hFFC, 32'h100};
        for (int i = 0; i < 5; i++) begin
            model_push(w_tab[i], a_tab[i], 32'h5A5A0000 + 32'(i), 4'hF);
            xact(0, w_tab[i], a_tab[i], 32'h5A5A0000 + 32'(i), 4'hF, rd, er, lat, one, tog, to);
            ex = sb_q.pop_front();
            checks++;
            if (to || rd !== ex.rdata || er !== ex.err) begin
                errors++;
                $display("FAIL err_case_%0d: addr=%h rdata=%h err=%b want %h %b", i, a_tab[i], rd, er, ex.rdata, ex.err);
            end
        end
    endtask

    task automatic test_back_to_back(input int d, input int period);
        int acc_q[$];
        req_write = 1'b1; req_addr = 32'h300; req_wdata = 32'h0BADF00D; req_wstrb = 4'hF;
        @(negedge clk);
        req_valid[d] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (req_ready[d] === 1'b1) acc_q.push_back(cyc + 1);
            @(negedge clk);
        end
        req_valid[d] = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (acc_q.size() < 4) begin
            errors++;
            $display("FAIL b2b_count_%0d: accepts=%0d want >=4", d, acc_q.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (acc_q[i] - acc_q[i-1] != period) begin
                    errors++;
                    $display("FAIL b2b_gap_%0d: gap=%0d want %0d", d, acc_q[i] - acc_q[i-1], period);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, tog; logic er, one, to; int lat; exp_t ex;
        int   t;
        logic saw_rsp;
        @(negedge clk);
        req_write = 1'b1; req_addr = 32'd52; req_wdata = 32'h000000FF; req_wstrb = 4'hF;
        req_valid[2] = 1'b1;
        t = 0;
        while (req_ready[2] !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        req_valid[2] = 1'b0;
        checks++;
        if (t >= 50 || req_ready[2] !== 1'b0) begin
            errors++;
            $display("FAIL abort_accept: ready=%b wait=%0d want 0 <50", req_ready[2], t);
        end
        @(negedge clk);
        resetn = 1'b0;
        model_tog = 32'd0;
        @(negedge clk);
        resetn = 1'b1;
        saw_rsp = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (rsp_valid[2] === 1'b1) saw_rsp = 1'b1;
        end
        checks++;
        if (saw_rsp || toggle_value[2] !== 32'd0 || req_ready[2] !== 1'b1) begin
            errors++;
            $display("FAIL abort_state: rsp_seen=%b toggle=%h ready=%b want 0 0 1", saw_rsp, toggle_value[2], req_ready[2]);
        end
        checks++;
        if (toggle_value[0] !== model_tog) begin
            errors++;
            $display("FAIL abort_toggle0: toggle=%h want %h", toggle_value[0], model_tog);
        end
        model_push(1'b0, 32'h100, 32'h0, 4'h0);
        xact(0, 1'b0, 32'h100, 32'h0, 4'h0, rd, er, lat, one, tog, to);
        ex = sb_q.pop_front();
        checks++;
        if (to || rd !== ex.rdata || er !== ex.err) begin
            errors++;
            $display("FAIL ram_retained: rdata=%h err=%b want %h %b", rd, er, ex.rdata, ex.err);
        end
    endtask

    initial begin
        resetn = 1'b0; req_valid = 3'b000; req_write = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; req_wstrb = 4'd0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        test_reset();
        test_store_load();
        test_toggle();
        test_byte_strobe();
        test_errors();
        test_back_to_back(1, 3);
        test_back_to_back(2, 6);
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
